// File: rtl/instr_mem_loader.sv
// instr_mem_loader: length-prefixed byte stream to big-endian 32-bit instruction memory writes
module instr_mem_loader #(
  parameter int DEPTH     = 250,
  parameter int BASE_WORD = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LEN_HI = 3'd1;
  localparam logic [2:0] LEN_LO = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;
  logic [2:0]  state_q, state_d;
  logic [15:0] len_q, len_d, widx_q, widx_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [31:0] word_q, word_d, addr_q, addr_d, wdata_q, wdata_d;
  logic        acc;
  logic [15:0] n;
  logic [16:0] end_word;
  assign byte_ready = state_q == LEN_HI || state_q == LEN_LO || state_q == DATA;
  assign acc        = byte_valid && byte_ready;
  assign n          = {len_q[15:8], byte_data};
  // 17-bit sum so a huge N cannot wrap past the bound
  assign end_word   = 17'(BASE_WORD) + {1'b0, n};
  assign mem_we     = state_q == WRITE;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = state_q == LEN_HI || state_q == LEN_LO || state_q == DATA || state_q == WRITE;
  assign done       = state_q == DONE;
  assign error      = state_q == ERR;
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, DONE, ERR: state_d = start ? LEN_HI : state_q;
      LEN_HI: if (acc) begin
        len_d[15:8] = byte_data;
        state_d     = LEN_LO;
      end
      LEN_LO: if (acc) begin
        len_d   = n;
        widx_d  = '0;
        bidx_d  = '0;
        state_d = n == '0 ? DONE : end_word > 17'(DEPTH) ? ERR : DATA;
      end
      DATA: if (acc) begin
        word_d = {word_q[23:0], byte_data};
        bidx_d = bidx_q + 2'd1;
        if (bidx_q == 2'd3) begin
          state_d = WRITE;
          addr_d  = (32'(BASE_WORD) + {16'd0, widx_q}) << 2;
          wdata_d = {word_q[23:0], byte_data};
        end
      end
      WRITE: begin
        state_d = widx_q == len_q - 16'd1 ? DONE : DATA;
        widx_d  = widx_q == len_q - 16'd1 ? widx_q : widx_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed and randomized loads checked against a stream-level reference model
module tb_instr_mem_loader;
  localparam int DEPTH = 250;
  localparam int BASE  = 10;
  logic clk = 0, rst_n, start, byte_valid, byte_ready, mem_we, busy, done, error;
  logic [7:0] byte_data;
  logic [31:0] mem_addr, mem_wdata;
  int tests = 0, fails = 0, cyc = 0;
  logic [7:0] stim[$];
  logic [31:0] wr_a[$], wr_d[$], exp_a[$], exp_d[$];
  int wr_c[$];

  instr_mem_loader #(.DEPTH(DEPTH), .BASE_WORD(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (mem_we) begin
      wr_a.push_back(mem_addr);
      wr_d.push_back(mem_wdata);
      wr_c.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  // gap < 0 selects a random 0..3 idle cycles before the byte
  task automatic send_byte(input logic [7:0] b, input int gap);
    int g, k;
    g = gap >= 0 ? gap : int'($urandom_range(0, 3));
    byte_valid = 0;
    repeat (g) @(negedge clk);
    byte_valid = 1;
    byte_data  = b;
    k = 0;
    while (!byte_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k == 50) chk("ready_timeout", 32'(byte_ready), 32'd1);
    @(negedge clk);
    byte_valid = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, 32'(byte_ready), 0);
    chk({tag, "_we"}, 32'(mem_we), 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
  endtask

  // Reference: N from the two length bytes, word w goes to byte address (BASE+w)*4
  task automatic run_load(input int gap, input int mid_start);
    int nw;
    bit ok;
    nw = int'({stim[0], stim[1]});
    ok = nw != 0 && BASE + nw <= DEPTH;
    exp_a.delete(); exp_d.delete(); wr_a.delete(); wr_d.delete(); wr_c.delete();
    if (ok) for (int w = 0; w < nw; w++) begin
      exp_a.push_back(32'((BASE + w) * 4));
      exp_d.push_back({stim[2+4*w], stim[3+4*w], stim[4+4*w], stim[5+4*w]});
    end
    pulse_start();
    send_byte(stim[0], gap);
    send_byte(stim[1], gap);
    if (!ok) begin
      chk("len_ready", 32'(byte_ready), 0);
      chk("len_done", 32'(done), 32'(nw == 0));
      chk("len_error", 32'(error), 32'(nw != 0));
      repeat (3) @(negedge clk);
      chk("stall_ready", 32'(byte_ready), 0);
      chk("stall_busy", 32'(busy), 0);
    end else begin
      for (int i = 0; i < 4 * nw; i++) begin
        if (i == mid_start) pulse_start();
        if (i % 4 == 3) chk("early_we", 32'(wr_a.size()), 32'(i / 4));
        send_byte(stim[2+i], gap);
        if (i % 4 == 3) begin
          chk("we", 32'(mem_we), 1);
          chk("addr", mem_addr, exp_a[i/4]);
          chk("wdata", mem_wdata, exp_d[i/4]);
        end
      end
      @(negedge clk);
      chk("end_done", 32'(done), 1);
      chk("end_busy", 32'(busy), 0);
      chk("end_we", 32'(mem_we), 0);
    end
    chk("wr_count", 32'(wr_a.size()), 32'(exp_a.size()));
    for (int w = 0; w < wr_a.size() && w < exp_a.size(); w++) begin
      chk("log_addr", wr_a[w], exp_a[w]);
      chk("log_data", wr_d[w], exp_d[w]);
    end
  endtask

  task automatic set_normal();
    stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h02, 8'h20, 8'h09, 8'h00, 8'h02};
  endtask

  initial begin
    logic [15:0] rn;
    rst_n = 0; start = 0; byte_valid = 0; byte_data = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1;
    @(negedge clk);
    chk("idle_ready", 32'(byte_ready), 0);
    set_normal();
    run_load(0, -1);
    chk("spacing", 32'(wr_c[1] - wr_c[0]), 5);
    chk("first_addr", wr_a[0], 32'd40);
    chk("first_data", wr_d[0], 32'h20080002);
    stim = '{8'h00, 8'h00};
    run_load(0, -1);
    stim = '{8'h00, 8'hF1};
    run_load(0, -1);
    stim = '{8'h00, 8'hF0};
    repeat (960) stim.push_back(8'($urandom));
    run_load(0, -1);
    chk("last_addr", wr_a[wr_a.size()-1], 32'd996);
    set_normal();
    run_load(3, -1);
    wr_a.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(stim[i], 0);
    rst_n = 0;
    @(negedge clk);
    check_idle_outputs("midrst");
    rst_n = 1;
    repeat (4) @(negedge clk);
    chk("midrst_nowrite", 32'(wr_a.size()), 0);
    run_load(0, -1);
    run_load(0, 2);
    chk("busy_start_count", 32'(wr_a.size()), 2);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("restart_done", 32'(done), 0);
    chk("restart_ready", 32'(byte_ready), 1);
    chk("restart_busy", 32'(busy), 1);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("restart_end", 32'(done), 1);
    for (int r = 0; r < 8; r++) begin
      case ($urandom_range(0, 3))
        0: rn = 16'd0;
        3: rn = 16'($urandom_range(241, 65535));
        default: rn = 16'($urandom_range(1, 6));
      endcase
      stim = '{rn[15:8], rn[7:0]};
      if (BASE + int'(rn) <= DEPTH) repeat (4 * int'(rn)) stim.push_back(8'($urandom));
      run_load(-1, -1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
